// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencer and its digit chain.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

endpackage

// File: rtl/stopwatch_seq_if.sv
// Command, digit-feedback and strobe bundle around stopwatch_seq.
// The lap capture signals exist only when STOPWATCH_LAP_EN is defined.
interface stopwatch_seq_if #(
  parameter int DIGITS = 4
) ();

  logic                  start_stop;
  logic                  clear;
  logic                  load;
  logic                  dir;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     dig_en;
  logic                  ctrl;
  logic                  set;
  logic [4*DIGITS-1:0]   set_val;
  logic                  running;
  logic                  done;
  logic                  ovf;
`ifdef STOPWATCH_LAP_EN
  logic                  lap;
  logic [4*DIGITS-1:0]   lap_val;
`endif

  // Drives commands and digit feedback; observes the sequencer outputs.
  modport master (
`ifdef STOPWATCH_LAP_EN
    output lap,
    input  lap_val,
`endif
    output start_stop, clear, load, dir, load_val, digits,
    input  dig_en, ctrl, set, set_val, running, done, ovf
  );

  modport slave (
`ifdef STOPWATCH_LAP_EN
    input  lap,
    output lap_val,
`endif
    input  start_stop, clear, load, dir, load_val, digits,
    output dig_en, ctrl, set, set_val, running, done, ovf
  );

endinterface

// File: rtl/stopwatch_prescaler.sv
// Time-base divider: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count for one cycle; holds its value while disabled.
module stopwatch_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == TERM);

  // NOTE: sequential state is written with non-blocking (<=) assignments only,
  // so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_seq.sv
// Stopwatch sequencer: run/pause/done FSM, prescaler and BCD carry/borrow chain.
// Optional lap capture register is built when STOPWATCH_LAP_EN is defined.
module stopwatch_seq
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int DIGITS   = 4
) (
  input logic             clk,
  input logic             reset,
  stopwatch_seq_if.slave  bus
);

  state_e                r_state;
  logic [DIGITS-1:0]     r_dig_en;
  logic                  r_ctrl;
  logic                  r_set;
  logic [4*DIGITS-1:0]   r_set_val;
  logic                  r_running;
  logic                  r_done;
  logic                  r_ovf;

  logic                  w_tick;
  logic                  w_psc_en;
  logic                  w_psc_clr;
  logic [DIGITS-1:0]     w_is9;
  logic [DIGITS-1:0]     w_is0;
  logic [DIGITS-1:0]     w_carry;
  logic                  w_all9;
  logic                  w_all0;

  assign w_psc_en  = (r_state == RUN);
  assign w_psc_clr = bus.clear | bus.load;

  stopwatch_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_psc_en),
    .i_clr  (w_psc_clr),
    .o_tick (w_tick)
  );

  // Digit k steps when every lower digit sits at the wrap value for the
  // latched direction; codes above 9 match neither 9 nor 0 and break the chain.
  // NOTE: every always_comb output gets a default before any branch or loop,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    logic l_pass;
    w_is9   = '0;
    w_is0   = '0;
    w_carry = '0;
    l_pass  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      w_is9[k]   = (bus.digits[4*k +: 4] == BCD_MAX);
      w_is0[k]   = (bus.digits[4*k +: 4] == BCD_MIN);
      w_carry[k] = l_pass;
      l_pass     = l_pass & ((r_ctrl == DOWN) ? w_is0[k] : w_is9[k]);
    end
  end

  assign w_all9 = &w_is9;
  assign w_all0 = &w_is0;

  // Strobes default low every cycle; clear beats load beats start_stop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_dig_en  <= '0;
      r_ctrl    <= UP;
      r_set     <= 1'b0;
      r_set_val <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_dig_en <= '0;
      r_ovf    <= 1'b0;
      r_set    <= 1'b0;

      if (bus.clear) begin
        r_state   <= IDLE;
        r_set     <= 1'b1;
        r_set_val <= '0;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else if (bus.load) begin
        r_set     <= 1'b1;
        r_set_val <= bus.load_val;
        if (r_state != IDLE) begin
          r_state   <= PAUSE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE, PAUSE: begin
            if (bus.start_stop) begin
              r_ctrl <= bus.dir;
              if (bus.dir == DOWN && w_all0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= RUN;
                r_running <= 1'b1;
              end
            end
          end

          RUN: begin
            if (r_ctrl == DOWN && w_all0) begin
              r_state   <= DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              if (w_tick) begin
                r_dig_en <= w_carry;
                r_ovf    <= (r_ctrl == UP) && w_all9;
              end
              if (bus.start_stop) begin
                r_state   <= PAUSE;
                r_running <= 1'b0;
              end
            end
          end

          DONE: begin
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dig_en  = r_dig_en;
  assign bus.ctrl    = r_ctrl;
  assign bus.set     = r_set;
  assign bus.set_val = r_set_val;
  assign bus.running = r_running;
  assign bus.done    = r_done;
  assign bus.ovf     = r_ovf;

`ifdef STOPWATCH_LAP_EN
  logic [4*DIGITS-1:0] r_lap_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lap_val <= '0;
    end else if (bus.clear) begin
      r_lap_val <= '0;
    end else if (bus.lap && r_state == RUN) begin
      r_lap_val <= bus.digits;
    end
  end

  assign bus.lap_val = r_lap_val;
`endif

endmodule

// File: tb/tb_stopwatch_seq.sv
// Directed bench for stopwatch_seq (TICK_DIV=4, DIGITS=2) with a small BCD
// counter chain closing the digit feedback loop; lap checks under STOPWATCH_LAP_EN.
module tb_stopwatch_seq;

  localparam int TD = 4;
  localparam int ND = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  stopwatch_seq_if #(.DIGITS(ND)) bus ();

  stopwatch_seq #(
    .TICK_DIV (TD),
    .DIGITS   (ND)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Digit chain: loads on set, otherwise each enabled digit steps one BCD count.
  logic [4*ND-1:0] r_cnt;

  function automatic logic [3:0] bump(input logic [3:0] v, input logic down);
    if (down) return (v == 4'd0) ? 4'd9 : v - 4'd1;
    return (v == 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (bus.set) begin
      r_cnt <= bus.set_val;
    end else begin
      for (int k = 0; k < ND; k++)
        if (bus.dig_en[k]) r_cnt[4*k +: 4] <= bump(r_cnt[4*k +: 4], bus.ctrl);
    end
  end

  assign bus.digits = r_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Caller sits at a negedge; the pulse is sampled by the next posedge.
  task automatic pulse(input logic c, input logic l, input logic s);
    bus.clear      = c;
    bus.load       = l;
    bus.start_stop = s;
    @(negedge clk);
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.start_stop = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.dig_en == '0 && n < 40);
    check("strobe_seen", 32'(bus.dig_en != '0), 32'h1);
  endtask

  task automatic quiet_cycles(input int n, output logic [ND-1:0] seen);
    seen = '0;
    repeat (n) begin
      @(negedge clk);
      seen |= bus.dig_en;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int              lat;
    logic [ND-1:0]   seen;

    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.dir        = 1'b0;
    bus.load_val   = '0;
`ifdef STOPWATCH_LAP_EN
    bus.lap        = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("rst_dig_en",  32'(bus.dig_en),  32'h0);
    check("rst_ctrl",    32'(bus.ctrl),    32'h0);
    check("rst_set",     32'(bus.set),     32'h0);
    check("rst_set_val", 32'(bus.set_val), 32'h0);
    check("rst_running", 32'(bus.running), 32'h0);
    check("rst_done",    32'(bus.done),    32'h0);
    check("rst_ovf",     32'(bus.ovf),     32'h0);
`ifdef STOPWATCH_LAP_EN
    check("rst_lap_val", 32'(bus.lap_val), 32'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Up count 00 -> 10: nine single-digit strobes, then a carry into digit 1.
    bus.dir = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    check("up_running", 32'(bus.running), 32'h1);
    for (int i = 1; i <= 10; i++) begin
      wait_strobe(lat);
      check("up_latency", 32'(lat), 32'(TD));
      check("up_dig_en",  32'(bus.dig_en), (i == 10) ? 32'h3 : 32'h1);
      check("up_ovf",     32'(bus.ovf), 32'h0);
    end

    // Up wrap from 99.
    pulse(1'b1, 1'b0, 1'b0);
    check("clr_set",     32'(bus.set),     32'h1);
    check("clr_set_val", 32'(bus.set_val), 32'h0);
    check("clr_running", 32'(bus.running), 32'h0);
    bus.load_val = 8'h99;
    pulse(1'b0, 1'b1, 1'b0);
    check("ld99_set",     32'(bus.set),     32'h1);
    check("ld99_set_val", 32'(bus.set_val), 32'h99);
    check("ld99_idle",    32'(bus.running), 32'h0);
    @(negedge clk);
    pulse(1'b0, 1'b0, 1'b1);
    wait_strobe(lat);
    check("wrap_latency", 32'(lat),        32'(TD));
    check("wrap_dig_en",  32'(bus.dig_en), 32'h3);
    check("wrap_ovf",     32'(bus.ovf),    32'h1);
    @(negedge clk);
    check("wrap_ovf_pulse", 32'(bus.ovf),     32'h0);
    check("wrap_running",   32'(bus.running), 32'h1);

    // Down count 10 -> 00 then DONE.
    pulse(1'b1, 1'b0, 1'b0);
    bus.load_val = 8'h10;
    pulse(1'b0, 1'b1, 1'b0);
    check("ld10_set",     32'(bus.set),     32'h1);
    check("ld10_set_val", 32'(bus.set_val), 32'h10);
    @(negedge clk);
    bus.dir = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    check("dn_ctrl",    32'(bus.ctrl),    32'h1);
    check("dn_running", 32'(bus.running), 32'h1);
    for (int i = 1; i <= 10; i++) begin
      wait_strobe(lat);
      check("dn_dig_en", 32'(bus.dig_en), (i == 1) ? 32'h3 : 32'h1);
    end
    @(negedge clk);
    check("dn_pre_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    check("dn_done",    32'(bus.done),    32'h1);
    check("dn_stopped", 32'(bus.running), 32'h0);
    quiet_cycles(12, seen);
    check("dn_no_en", 32'(seen), 32'h0);

    // Down start from zero goes straight to DONE.
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.dir = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    check("zero_done",    32'(bus.done),    32'h1);
    check("zero_running", 32'(bus.running), 32'h0);
    quiet_cycles(12, seen);
    check("zero_no_en", 32'(seen), 32'h0);

    // Pause with prescaler held at 2, resume: strobe two cycles later.
    pulse(1'b1, 1'b0, 1'b0);
    bus.dir = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    pulse(1'b0, 1'b0, 1'b1);
    check("pause_running", 32'(bus.running), 32'h0);
    quiet_cycles(10, seen);
    check("pause_no_en", 32'(seen), 32'h0);
    pulse(1'b0, 1'b0, 1'b1);
    check("resume_running", 32'(bus.running), 32'h1);
    wait_strobe(lat);
    check("resume_latency", 32'(lat),        32'h2);
    check("resume_dig_en",  32'(bus.dig_en), 32'h1);

    // clear + load + start_stop together: clear wins.
    bus.load_val = 8'h55;
    pulse(1'b1, 1'b1, 1'b1);
    check("all3_set",     32'(bus.set),     32'h1);
    check("all3_set_val", 32'(bus.set_val), 32'h0);
    check("all3_running", 32'(bus.running), 32'h0);
    check("all3_done",    32'(bus.done),    32'h0);
    quiet_cycles(8, seen);
    check("all3_no_en",   32'(seen),        32'h0);
    check("all3_idle",    32'(bus.running), 32'h0);

    // clear in the tick cycle suppresses the strobe.
    pulse(1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0);
    check("clrtick_dig_en",  32'(bus.dig_en),  32'h0);
    check("clrtick_set",     32'(bus.set),     32'h1);
    check("clrtick_running", 32'(bus.running), 32'h0);

    // start_stop in the tick cycle: strobe still issued, then paused.
    pulse(1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    pulse(1'b0, 1'b0, 1'b1);
    check("sstick_dig_en",  32'(bus.dig_en),  32'h1);
    check("sstick_running", 32'(bus.running), 32'h0);
    quiet_cycles(8, seen);
    check("sstick_no_en", 32'(seen), 32'h0);

    // Asynchronous reset in the middle of a down run.
    pulse(1'b1, 1'b0, 1'b0);
    bus.load_val = 8'h42;
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.dir = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    wait_strobe(lat);
    check("pre_rst_dig_en", 32'(bus.dig_en), 32'h1);
    check("pre_rst_ctrl",   32'(bus.ctrl),   32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dig_en",  32'(bus.dig_en),  32'h0);
    check("arst_ctrl",    32'(bus.ctrl),    32'h0);
    check("arst_set_val", 32'(bus.set_val), 32'h0);
    check("arst_running", 32'(bus.running), 32'h0);
    check("arst_done",    32'(bus.done),    32'h0);
    check("arst_ovf",     32'(bus.ovf),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef STOPWATCH_LAP_EN
    bus.load_val = 8'h36;
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.dir = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    wait_strobe(lat);
    @(negedge clk);
    bus.lap = 1'b1;
    @(negedge clk);
    bus.lap = 1'b0;
    check("lap_val",     32'(bus.lap_val), 32'h37);
    check("lap_running", 32'(bus.running), 32'h1);
    wait_strobe(lat);
    check("lap_counting", 32'(bus.dig_en), 32'h1);
    pulse(1'b1, 1'b0, 1'b0);
    check("lap_clr", 32'(bus.lap_val), 32'h0);
    bus.lap = 1'b1;
    @(negedge clk);
    bus.lap = 1'b0;
    check("lap_idle", 32'(bus.lap_val), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_seq.md
# stopwatch_seq

Sequencer for the stopwatch BCD digit-counter chain. Owns the run/pause/done state machine, the time-base prescaler and the carry/borrow logic between digits. Issues one-cycle count enables, direction and load commands to the per-digit up/down counters, and reads their current values back. Sits between the debounced push-button pulses and the digit datapath.

## Interface
- TICK_DIV, 1000: clk cycles per least-significant-digit step; legal range 2..2^20
- DIGITS, 4: number of BCD digits in the chain; legal range 1..8
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start_stop  in  1  one-cycle pulse; toggles between running and paused
- clear  in  1  one-cycle pulse; zero all digits and stop
- load  in  1  one-cycle pulse; preset digits from load_val
- dir  in  1  0 = count up, 1 = count down; sampled only on entry to RUN
- load_val  in  4*DIGITS  BCD preset, digit 0 in bits [3:0]
- digits  in  4*DIGITS  current counter values fed back from the chain
- dig_en  out  DIGITS  per-digit count enable, one-cycle strobe
- ctrl  out  1  latched direction to the counters (0 up, 1 down)
- set  out  1  one-cycle load strobe to all counters
- set_val  out  4*DIGITS  value loaded while set is high
- running  out  1  high in RUN
- done  out  1  high in DONE
- ovf  out  1  one-cycle pulse on up-count wrap from all-9s

## Operation
- States: IDLE, RUN, PAUSE, DONE. All outputs registered.
- Command priority in any state: clear > load > start_stop. Lower-priority pulses in the same cycle are dropped.
- clear: go to IDLE, set=1 for one cycle, set_val=0, prescaler=0.
- load: set=1 for one cycle, set_val=load_val, prescaler=0.
  - From RUN, PAUSE or DONE: go to PAUSE.
  - From IDLE: stay in IDLE.
- start_stop transitions:
  - IDLE or PAUSE -> RUN, latching ctrl=dir.
  - RUN -> PAUSE.
  - DONE: ignored.
- Down-count guard: when entering RUN with dir=1 and digits all zero, go to DONE instead.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN. Tick occurs at terminal count, then wraps to 0.
  - Holds its value in PAUSE, so resume keeps sub-digit phase.
- Carry chain, on tick:
  - dig_en[0]=1.
  - dig_en[k]=1 iff every digit below k is 9 (up) or 0 (down).
- Up wrap: tick with all digits 9 -> all dig_en high, ovf=1, stay in RUN.
- Down terminal: in RUN with ctrl=1, digits all zero -> DONE on the next edge; no further dig_en.
- Digit values >9 on the digits input are treated as not-9 and not-0.

## Timing
- Reset values:
  - State = IDLE, prescaler = 0.
  - dig_en = 0, ctrl = 0, set = 0, set_val = 0.
  - running = 0, done = 0, ovf = 0.
- dig_en and ovf assert the cycle after the prescaler terminal count.
- First dig_en after entering RUN from IDLE appears TICK_DIV cycles after the start_stop edge.
- set asserts the cycle after the clear/load pulse. The counters show the new value one cycle later.
- running and done update the cycle after the triggering event.
- A clear in the same cycle as a tick suppresses dig_en and ovf.
- start_stop in the same cycle as a tick, from RUN: dig_en for that tick is still issued, then PAUSE.
- TICK_DIV >= 2 guarantees digit feedback has settled before the next carry evaluation.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

## Configuration
- STOPWATCH_LAP_EN defined:
  - Adds input lap (one-cycle pulse) and output lap_val (4*DIGITS, reset 0).
  - In RUN, lap captures digits into lap_val on the next edge.
  - clear zeroes lap_val; lap outside RUN is ignored.
- Undefined: no lap port and no lap register; behaviour otherwise identical.

## Structure
- Shared package stopwatch_pkg holds:
  - state enum typedef (IDLE, RUN, PAUSE, DONE)
  - BCD_MAX = 4'd9 and BCD_MIN = 4'd0 constants
  - direction constants UP=0, DOWN=1
- Sub-module stopwatch_prescaler: TICK_DIV counter with enable and synchronous clear, one-cycle tick output.
- Carry chain and FSM stay in the top module.

## Test plan
- TICK_DIV=4, DIGITS=2, dir=0, start_stop:
  - dig_en=01 every 4 cycles.
  - When digits=09, dig_en=11.
  - When digits=99, dig_en=11 and ovf=1.
- load_val=0x10, load, dir=1, start_stop:
  - set=1 with set_val=0x10.
  - Down steps through 0x09 … 0x00, then done=1, running=0, dig_en stays 0.
- From IDLE at zero: dir=1, start_stop -> done=1 next cycle, no dig_en ever.
- Running: start_stop mid-prescale (count 2 of 4), hold 10 cycles, start_stop -> next dig_en arrives 2 cycles after resume.
- clear, load and start_stop in the same cycle -> set_val=0, state IDLE.
- Separately: clear coincident with a tick -> no dig_en.
- Reset pulse mid-RUN -> all outputs 0 immediately.
- With STOPWATCH_LAP_EN: lap at digits=0x37 -> lap_val=0x37 while counting continues; clear -> lap_val=0.
